// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: capture FSM encoding and default word width.
package uart_pkg;

    localparam int unsigned DATA_SIZE_DEFAULT = 7;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } cap_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; push while full is dropped unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == CW'(0));
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// Captures frames from the receiver shift register into a FIFO with overrun/framing-error flags.
// Define UART_RX_FIFO_FERR_EN to store the frame-error bit per entry and expose rd_ferr.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEFAULT,
    parameter int unsigned DEPTH     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_SIZE-1:0]    rsr_data,
    input  logic                    rsr_data_ready,
    input  logic                    rsr_frame_error,
    output logic                    rsr_ack,
    output logic [DATA_SIZE-1:0]    rd_data,
    output logic                    rd_valid,
    input  logic                    rd_ready,
`ifdef UART_RX_FIFO_FERR_EN
    output logic                    rd_ferr,
`endif
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overrun,
    output logic                    ferr_sticky,
    input  logic                    clear_err
);

`ifdef UART_RX_FIFO_FERR_EN
    localparam int unsigned WIDTH = DATA_SIZE + 1;
`else
    localparam int unsigned WIDTH = DATA_SIZE;
`endif

    cap_state_t       state;
    logic             capture_c;
    logic             push_c;
    logic             pop_c;
    logic             drop_c;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_din;
    logic [WIDTH-1:0] fifo_dout;

    // A frame is processed only on the IDLE cycle that first sees it pending.
    assign capture_c = (state == IDLE) && rsr_data_ready;

`ifdef UART_RX_FIFO_FERR_EN
    assign push_c   = capture_c;
    assign fifo_din = {rsr_frame_error, rsr_data};
    assign rd_ferr  = fifo_dout[DATA_SIZE];
`else
    assign push_c   = capture_c && !rsr_frame_error;
    assign fifo_din = rsr_data;
`endif

    assign rd_data  = fifo_dout[DATA_SIZE-1:0];
    assign rd_valid = !fifo_empty;
    assign pop_c    = rd_ready && rd_valid;
    assign drop_c   = push_c && !rsr_frame_error && fifo_full && !pop_c;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .pop   (pop_c),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (count)
    );

    // Capture handshake FSM and sticky flags; set events take priority over clear_err.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rsr_ack     <= 1'b0;
            overrun     <= 1'b0;
            ferr_sticky <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rsr_data_ready) begin
                        state   <= ACK;
                        rsr_ack <= 1'b1;
                    end
                end
                ACK: begin
                    if (!rsr_data_ready) begin
                        state   <= IDLE;
                        rsr_ack <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rsr_ack <= 1'b0;
                end
            endcase

            if (clear_err) begin
                overrun     <= 1'b0;
                ferr_sticky <= 1'b0;
            end
            if (drop_c) begin
                overrun <= 1'b1;
            end
            if (capture_c && rsr_frame_error) begin
                ferr_sticky <= 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DATA_SIZE, default 7, receive data width in bits.
REQ-002 Parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-003 clk  input  1  clock; all logic on posedge clk.
REQ-004 reset  input  1  reset: synchronous, active-high.
REQ-005 rsr_data  input  DATA_SIZE  received word from the receiver shift register.
REQ-006 rsr_data_ready  input  1  receiver has a completed frame pending.
REQ-007 rsr_frame_error  input  1  pending frame had a bad stop bit.
REQ-008 rsr_ack  output  1  acknowledge to the receiver (its data_read_ack).
REQ-009 rd_data  output  DATA_SIZE  head-of-FIFO word, show-ahead.
REQ-010 rd_valid  output  1  FIFO non-empty.
REQ-011 rd_ready  input  1  consumer pops the head when rd_valid is also 1.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-013 overrun  output  1  sticky: a good frame was dropped because the FIFO was full.
REQ-014 ferr_sticky  output  1  sticky: a frame with a framing error was received.
REQ-015 clear_err  input  1  clears overrun and ferr_sticky.

Function
REQ-016 The capture FSM SHALL have two states: IDLE and ACK.
REQ-017 IDLE: rsr_data_ready=1 -> process the frame, next state ACK, rsr_ack registered to 1.
REQ-018 ACK: rsr_ack held at 1 until rsr_data_ready samples 0; on that cycle rsr_ack<=0 and the FSM returns to IDLE.
REQ-019 Each frame SHALL be processed exactly once, regardless of how long rsr_data_ready stays high.
REQ-020 Processing a good frame (rsr_frame_error=0) SHALL push rsr_data; the word appears on rd_data/rd_valid one cycle after the cycle in which rsr_data_ready was sampled in IDLE.
REQ-021 Processing an errored frame SHALL set ferr_sticky and SHALL NOT push (when UART_RX_FIFO_FERR_EN is undefined).
REQ-022 Pop occurs when rd_valid and rd_ready are both 1; rd_data shows the next entry on the following cycle.
REQ-023 A pop while empty SHALL be ignored.
REQ-024 Push when count=DEPTH and no pop in the same cycle: word dropped, overrun<=1, FIFO unchanged, rsr_ack still issued.
REQ-025 Push and pop in the same cycle: both take effect and count is unchanged, including when full.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; count SHALL equal writes minus pops.
REQ-027 clear_err clears both sticky flags; a set event in the same cycle SHALL win over clear.

Reset
REQ-028 Reset SHALL force FSM=IDLE, rsr_ack=0, pointers=0, count=0, rd_valid=0, overrun=0, ferr_sticky=0; rd_data undefined until the first push; memory contents not cleared.
REQ-029 Reset asserted mid-ACK SHALL drop rsr_ack on the next edge; a frame still pending afterwards SHALL be processed again as new.

Configuration
REQ-030 Macro UART_RX_FIFO_FERR_EN: when defined, each entry stores DATA_SIZE+1 bits, errored frames are pushed with their frame-error bit, and output rd_ferr (1 bit, the head entry's error bit) exists; ferr_sticky still sets.
REQ-031 Without UART_RX_FIFO_FERR_EN, rd_ferr SHALL be absent and errored frames SHALL be discarded as in REQ-021.

Structure
REQ-032 The shared package uart_pkg SHALL hold the capture FSM state encoding and the default DATA_SIZE constant.
REQ-033 Storage and pointers SHALL live in sub-module sync_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, empty, full, count); the capture FSM and flags live in uart_rx_fifo.

Verification
REQ-034 Single frame: 0x55 with rsr_data_ready held 20 cycles -> exactly one push, rd_data=0x55, count=1, one rsr_ack high window that ends the cycle after ready falls.
REQ-035 Fill: 9 good frames 0x01..0x09, DEPTH=8, no reads -> count=8, overrun=1, pops return 0x01..0x08, 0x09 lost.
REQ-036 Frame error: frame 0x7F with rsr_frame_error=1 -> without the macro count stays 0 and ferr_sticky=1; with the macro count=1 and rd_ferr=1.
REQ-037 Full with simultaneous push/pop: count=8, push 0x2A while popping -> count=8, overrun=0, 0x2A is read last after 7 further pops.
REQ-038 Wrap: 20 frames interleaved with reads at rd_ready=1 -> in-order data 0..19 and no overrun.
REQ-039 Reset while in ACK with 3 entries -> next cycle count=0, rd_valid=0, rsr_ack=0, flags cleared.
